// File: rtl/change_event_recorder.sv
// change_event_recorder
//
// Purpose:
//   Samples a small bus of signals every clock and, whenever the sampled
//   value differs from the previous sample, builds an event record
//   {timestamp, value, OR-reduction of value} and pushes it into a FIFO.
//   A consumer drains the FIFO with a valid/ready handshake. When the FIFO
//   is full and no pop frees a slot, the record is dropped and a sticky
//   overflow flag is raised.
//
// Ports:
//   clk       in   1               rising-edge clock
//   rst       in   1               asynchronous reset, active-high
//   sig_in    in   WIDTH           monitored signals, sampled on clk
//   ev_valid  out  1               FIFO head holds a record
//   ev_ready  in   1               consumer accepts head this cycle
//   ev_data   out  TS_W+WIDTH+1    {ts, value, or_val}; 0 when FIFO empty
//   overflow  out  1               sticky: at least one record was dropped
//   drop_cnt  out  8               saturating dropped-record count
//                                  (only when CER_DROP_CNT_EN is defined)
//
// Configuration macro:
//   CER_DROP_CNT_EN  adds the drop_cnt port and its counter.

module change_event_recorder #(
  parameter int WIDTH = 3,
  parameter int TS_W  = 16,
  parameter int DEPTH = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [WIDTH-1:0]        sig_in,
  output logic                    ev_valid,
  input  logic                    ev_ready,
  output logic [TS_W+WIDTH:0]     ev_data,
  output logic                    overflow
`ifdef CER_DROP_CNT_EN
  ,
  output logic [7:0]              drop_cnt
`endif
);

  localparam int RW = TS_W + WIDTH + 1;
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic [TS_W-1:0]  ts_cnt_q, ts_cnt_d;
  logic [WIDTH-1:0] prev_q, prev_d;
  logic             overflow_q, overflow_d;
  logic [RW-1:0]    mem_q [DEPTH];

  logic             not_empty;
  logic             full;
  logic             change;
  logic             pop;
  logic             push;
  logic             drop;
  logic [RW-1:0]    record;

  always_comb begin
    not_empty = (count_q != '0);
    full      = (count_q == (AW+1)'(DEPTH));
    change    = (sig_in != prev_q);
    pop       = not_empty && ev_ready;
    // A pop at the same edge frees the slot the push needs, so a full FIFO
    // still accepts the record in that case.
    push      = change && (!full || pop);
    drop      = change && full && !pop;
    // Timestamp is the pre-increment counter value of this edge.
    record    = {ts_cnt_q, sig_in, |sig_in};

    wr_ptr_d   = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d   = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d    = count_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    ts_cnt_d   = ts_cnt_q + TS_W'(1);
    prev_d     = sig_in;
    overflow_d = overflow_q | drop;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      ts_cnt_q   <= '0;
      prev_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      ts_cnt_q   <= ts_cnt_d;
      prev_q     <= prev_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage needs no reset: stale entries are never visible because the
  // output is gated by occupancy.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= record;
    end
  end

  assign ev_valid = not_empty;
  assign ev_data  = not_empty ? mem_q[rd_ptr_q] : '0;
  assign overflow = overflow_q;

`ifdef CER_DROP_CNT_EN
  logic [7:0] drop_cnt_q, drop_cnt_d;

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (drop && (drop_cnt_q != 8'hFF)) begin
      drop_cnt_d = drop_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop_cnt_q <= '0;
    end else begin
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign drop_cnt = drop_cnt_q;
`endif

endmodule

// File: tb/tb_change_event_recorder.sv
// Testbench for change_event_recorder: table-driven vectors plus directed
// multi-cycle sequences. A second instance with TS_W=4 exercises timestamp
// wrap. Inputs change and outputs are sampled 1 time unit after rising edges.

module tb_change_event_recorder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  sig_in = 3'b000;
  logic        ev_ready = 1'b0;
  logic        ev_valid;
  logic [19:0] ev_data;
  logic        overflow;

  logic [2:0]  sig4 = 3'b000;
  logic        ready4 = 1'b0;
  logic        ev_valid4;
  logic [7:0]  ev_data4;
  logic        overflow4;

`ifdef CER_DROP_CNT_EN
  logic [7:0]  drop_cnt;
  logic [7:0]  drop_cnt4;
`endif

  int checks   = 0;
  int failures = 0;
  int edge_n   = 0;

  always #5 clk = ~clk;

  change_event_recorder #(.WIDTH(3), .TS_W(16), .DEPTH(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .sig_in   (sig_in),
    .ev_valid (ev_valid),
    .ev_ready (ev_ready),
    .ev_data  (ev_data),
    .overflow (overflow)
`ifdef CER_DROP_CNT_EN
    ,
    .drop_cnt (drop_cnt)
`endif
  );

  change_event_recorder #(.WIDTH(3), .TS_W(4), .DEPTH(8)) dut4 (
    .clk      (clk),
    .rst      (rst),
    .sig_in   (sig4),
    .ev_valid (ev_valid4),
    .ev_ready (ready4),
    .ev_data  (ev_data4),
    .overflow (overflow4)
`ifdef CER_DROP_CNT_EN
    ,
    .drop_cnt (drop_cnt4)
`endif
  );

  function automatic logic [31:0] mk(input int ts, input logic [2:0] v);
    logic [15:0] t;
    t  = ts[15:0];
    mk = {12'd0, t, v, |v};
  endfunction

  function automatic logic [31:0] mk4(input int ts, input logic [2:0] v);
    logic [3:0] t;
    t   = ts[3:0];
    mk4 = {24'd0, t, v, |v};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
    end else begin
      $display("ok   %s value=%0h", nm, act);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    edge_n++;
  endtask

  // Holds reset over two edges and releases it just after an edge, so the
  // next edge is the first one counted (ts 0).
  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    edge_n = 0;
  endtask

  typedef struct {
    int          at_ts;
    logic [2:0]  sig;
    logic [31:0] exp;
  } vec_t;

  vec_t t2[3];
  vec_t t3[10];

  initial begin
    // Vector tables
    t2[0] = '{10, 3'b001, mk(10, 3'b001)};
    t2[1] = '{20, 3'b011, mk(20, 3'b011)};
    t2[2] = '{30, 3'b111, mk(30, 3'b111)};
    for (int i = 0; i < 10; i++) begin
      logic [2:0] v;
      v = 3'((i + 1) % 8);
      t3[i] = '{i, v, mk(i, v)};
    end

    // 1: idle bus produces nothing
    ev_ready = 1'b0;
    sig_in   = 3'b000;
    do_reset();
    chk("reset_valid", 32'(ev_valid), 32'd0);
    chk("reset_data", 32'(ev_data), 32'd0);
    chk("reset_overflow", 32'(overflow), 32'd0);
    for (int i = 0; i < 20; i++) begin
      tick();
      if (ev_valid !== 1'b0) chk("t1_idle_valid", 32'(ev_valid), 32'd0);
    end
    chk("t1_idle_valid_end", 32'(ev_valid), 32'd0);
    chk("t1_overflow", 32'(overflow), 32'd0);

    // 2: three spaced changes, consumer always ready
    do_reset();
    ev_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      while (edge_n < t2[i].at_ts) tick();
      sig_in = t2[i].sig;
      tick();
      chk("t2_valid", 32'(ev_valid), 32'd1);
      chk("t2_data", 32'(ev_data), t2[i].exp);
      tick();
      chk("t2_popped", 32'(ev_valid), 32'd0);
    end

    // 3: ten consecutive changes with no consumer, then drain
    ev_ready = 1'b0;
    sig_in   = 3'b000;
    do_reset();
    for (int i = 0; i < 10; i++) begin
      sig_in = t3[i].sig;
      tick();
      if (i == 7) chk("t3_ovf_before", 32'(overflow), 32'd0);
      if (i == 8) chk("t3_ovf_ninth", 32'(overflow), 32'd1);
    end
`ifdef CER_DROP_CNT_EN
    chk("t3_drop_cnt", 32'(drop_cnt), 32'd2);
`endif
    ev_ready = 1'b1;
    for (int j = 0; j < 8; j++) begin
      chk("t3_drain_valid", 32'(ev_valid), 32'd1);
      chk("t3_drain_data", 32'(ev_data), t3[j].exp);
      tick();
    end
    chk("t3_empty", 32'(ev_valid), 32'd0);
    chk("t3_empty_data", 32'(ev_data), 32'd0);
    chk("t3_ovf_sticky", 32'(overflow), 32'd1);

    // 4: full FIFO, change and pop at the same edge
    ev_ready = 1'b0;
    sig_in   = 3'b000;
    do_reset();
    chk("t4_ovf_cleared", 32'(overflow), 32'd0);
    for (int i = 0; i < 8; i++) begin
      sig_in = t3[i].sig;
      tick();
    end
    sig_in   = 3'b101;
    ev_ready = 1'b1;
    tick();
    chk("t4_ovf", 32'(overflow), 32'd0);
    for (int j = 1; j < 8; j++) begin
      chk("t4_drain_data", 32'(ev_data), t3[j].exp);
      tick();
    end
    chk("t4_tail_valid", 32'(ev_valid), 32'd1);
    chk("t4_tail_data", 32'(ev_data), mk(8, 3'b101));
    tick();
    chk("t4_empty", 32'(ev_valid), 32'd0);

    // 5: nonzero value held through reset, plus timestamp wrap on TS_W=4
    ev_ready = 1'b0;
    ready4   = 1'b0;
    sig_in   = 3'b101;
    sig4     = 3'b000;
    do_reset();
    chk("t5_reset_valid", 32'(ev_valid), 32'd0);
    tick();
    chk("t5_first_valid", 32'(ev_valid), 32'd1);
    chk("t5_first_data", 32'(ev_data), mk(0, 3'b101));
    tick();
    tick();
    ev_ready = 1'b1;
    tick();
    chk("t5_only_one", 32'(ev_valid), 32'd0);
    while (edge_n < 15) tick();
    sig4 = 3'b001;
    tick();
    sig4 = 3'b010;
    tick();
    chk("t5_wrap_ts15", 32'(ev_data4), mk4(15, 3'b001));
    ready4 = 1'b1;
    tick();
    chk("t5_wrap_ts0", 32'(ev_data4), mk4(16, 3'b010));
    tick();
    chk("t5_wrap_empty", 32'(ev_valid4), 32'd0);
    ready4 = 1'b0;

    // 6: reset mid-drain
    ev_ready = 1'b0;
    sig_in   = 3'b000;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      sig_in = 3'(i + 1);
      tick();
    end
    ev_ready = 1'b1;
    tick();
    ev_ready = 1'b0;
    tick();
    chk("t6_head", 32'(ev_data), mk(1, 3'b010));
    ev_ready = 1'b1;
    #3;
    rst = 1'b1;
    #1;
    chk("t6_async_valid", 32'(ev_valid), 32'd0);
    chk("t6_async_data", 32'(ev_data), 32'd0);
    chk("t6_async_ovf", 32'(overflow), 32'd0);
    sig_in = 3'b110;
    do_reset();
    tick();
    chk("t6_restart_valid", 32'(ev_valid), 32'd1);
    chk("t6_restart_data", 32'(ev_data), mk(0, 3'b110));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
